// File: rtl/systolic_tile_scheduler.sv
// Tile scheduler: walks a job's tiles through a systolic controller, stepping weight/activation addresses.
// Optional TILE_SCHED_PERF_EN adds a saturating busy-cycle counter on perf_cycles.
module systolic_tile_scheduler #(
  parameter int ADDR_W    = 16,
  parameter int TILE_W    = 8,
  parameter int WT_STRIDE = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [TILE_W-1:0] job_num_tiles,
  input  logic [7:0]        job_rows,
  input  logic [ADDR_W-1:0] job_wt_base,
  input  logic [ADDR_W-1:0] job_act_base,
  input  logic              job_abort,
  output logic              sys_start,
  output logic [7:0]        sys_rows,
  input  logic              sys_busy,
  input  logic              sys_done,
  output logic [ADDR_W-1:0] wt_addr,
  output logic [ADDR_W-1:0] act_addr,
  output logic              acc_clear,
  output logic              acc_last,
  output logic [TILE_W-1:0] tile_idx,
  output logic              sched_busy,
  output logic              job_done,
`ifdef TILE_SCHED_PERF_EN
  output logic [31:0]       perf_cycles,
`endif
  output logic              job_aborted
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_DONE, NEXT, DRAIN, FINISH, ABORT
  } state_t;

  state_t            state, state_nx;
  logic [TILE_W-1:0] num_tiles;
  logic              accept, is_last;

  assign accept  = (state == IDLE) && job_valid;
  assign is_last = (tile_idx == num_tiles - TILE_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (job_valid) state_nx = (job_num_tiles == '0) ? FINISH : ISSUE;
      ISSUE:     if (job_abort) state_nx = ABORT;
                 else if (!sys_busy) state_nx = WAIT_DONE;
      // a done coinciding with abort still retires the tile, so no drain is needed
      WAIT_DONE: if (sys_done) state_nx = job_abort ? ABORT : (is_last ? FINISH : NEXT);
                 else if (job_abort) state_nx = DRAIN;
      NEXT:      state_nx = job_abort ? ABORT : ISSUE;
      DRAIN:     if (sys_done) state_nx = ABORT;
      FINISH:    state_nx = IDLE;
      ABORT:     state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_tiles <= '0;
      sys_rows  <= '0;
      tile_idx  <= '0;
      wt_addr   <= '0;
      act_addr  <= '0;
    end else if (accept) begin
      num_tiles <= job_num_tiles;
      sys_rows  <= job_rows;
      tile_idx  <= '0;
      wt_addr   <= job_wt_base;
      act_addr  <= job_act_base;
    end else if (state == NEXT) begin
      tile_idx  <= tile_idx + TILE_W'(1);
      wt_addr   <= wt_addr + ADDR_W'(WT_STRIDE);
      act_addr  <= act_addr + ADDR_W'(sys_rows);
    end
  end

  assign job_ready   = (state == IDLE);
  assign sched_busy  = (state != IDLE);
  assign sys_start   = (state == ISSUE) && !sys_busy;
  assign acc_clear   = sys_start && (tile_idx == '0);
  assign acc_last    = sys_start && is_last;
  assign job_done    = (state == FINISH);
  assign job_aborted = (state == ABORT);

`ifdef TILE_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                           perf_cycles <= '0;
    else if (accept)                   perf_cycles <= 32'd1;
    else if (sched_busy && perf_cycles != 32'hFFFF_FFFF) perf_cycles <= perf_cycles + 32'd1;
  end
`endif

endmodule
